// File: rtl/button_event_gen.sv
// Per-button press/release/long/repeat detection for two debounced buttons.
// Events go through one pending slot per button into a valid/ready output register.
module button_event_gen #(
    parameter int CNT_W         = 16,
    parameter int LONG_PRESS    = 1000,
    parameter int REPEAT_PERIOD = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] button_db,
    output logic [1:0] press_pulse,
    output logic [1:0] release_pulse,
    output logic [1:0] long_pulse,
    output logic [1:0] repeat_pulse,
    output logic [1:0] held,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [2:0] evt_code,
    output logic       evt_overflow
);

    // Handshake: evt_code is transferred on a rising edge where evt_valid & evt_ready;
    // while evt_valid & !evt_ready, evt_valid and evt_code hold their values.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHORT = 2'd1,
        LONG  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [1:0] EV_PRESS   = 2'd0;
    localparam logic [1:0] EV_RELEASE = 2'd1;
    localparam logic [1:0] EV_LONG    = 2'd2;
    localparam logic [1:0] EV_REPEAT  = 2'd3;

    state_e           state_q [2];
    state_e           state_d [2];
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       ev_fire;
    logic [1:0][1:0]  ev_type;

    logic [1:0] press_q, release_q, long_q, repeat_q;

    logic            out_free;
    logic [1:0]      drain;
    logic [1:0]      drop;
    logic [1:0]      pend_valid_q, pend_valid_d;
    logic [1:0][1:0] pend_type_q, pend_type_d;
    logic            out_valid_q, out_valid_d;
    logic [2:0]      out_code_q, out_code_d;
    logic            ovf_q, ovf_d;

    // Button FSMs: release is checked first so it wins over long/repeat.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            state_d[b] = state_q[b];
            cnt_d[b]   = cnt_q[b];
            ev_fire[b] = 1'b0;
            ev_type[b] = EV_PRESS;
            case (state_q[b])
                IDLE: begin
                    if (button_db[b]) begin
                        state_d[b] = SHORT;
                        cnt_d[b]   = '0;
                        ev_fire[b] = 1'b1;
                        ev_type[b] = EV_PRESS;
                    end
                end
                SHORT: begin
                    if (!button_db[b]) begin
                        state_d[b] = IDLE;
                        ev_fire[b] = 1'b1;
                        ev_type[b] = EV_RELEASE;
                    end else if (cnt_q[b] == LONG_LAST) begin
                        state_d[b] = LONG;
                        cnt_d[b]   = '0;
                        ev_fire[b] = 1'b1;
                        ev_type[b] = EV_LONG;
                    end else begin
                        cnt_d[b] = cnt_q[b] + 1'b1;
                    end
                end
                LONG: begin
                    if (!button_db[b]) begin
                        state_d[b] = IDLE;
                        ev_fire[b] = 1'b1;
                        ev_type[b] = EV_RELEASE;
                    end else if (cnt_q[b] == REP_LAST) begin
                        cnt_d[b]   = '0;
                        ev_fire[b] = 1'b1;
                        ev_type[b] = EV_REPEAT;
                    end else begin
                        cnt_d[b] = cnt_q[b] + 1'b1;
                    end
                end
                default: state_d[b] = IDLE;
            endcase
        end
    end

    // Output register refills from pending slots; button 0 wins, drain happens before refill.
    always_comb begin
        out_free    = !out_valid_q || evt_ready;
        drain[0]    = out_free && pend_valid_q[0];
        drain[1]    = out_free && pend_valid_q[1] && !pend_valid_q[0];
        out_valid_d = out_valid_q;
        out_code_d  = out_code_q;
        if (out_free) begin
            out_valid_d = |pend_valid_q;
            if (pend_valid_q[0]) begin
                out_code_d = {1'b0, pend_type_q[0]};
            end else if (pend_valid_q[1]) begin
                out_code_d = {1'b1, pend_type_q[1]};
            end
        end
        for (int b = 0; b < 2; b++) begin
            pend_valid_d[b] = pend_valid_q[b] && !drain[b];
            pend_type_d[b]  = pend_type_q[b];
            drop[b]         = 1'b0;
            if (ev_fire[b]) begin
                if (pend_valid_d[b]) begin
                    drop[b] = 1'b1;
                end else begin
                    pend_valid_d[b] = 1'b1;
                    pend_type_d[b]  = ev_type[b];
                end
            end
        end
        ovf_d = ovf_q || (|drop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= IDLE;
                cnt_q[b]   <= '0;
            end
            press_q      <= '0;
            release_q    <= '0;
            long_q       <= '0;
            repeat_q     <= '0;
            pend_valid_q <= '0;
            pend_type_q  <= '0;
            out_valid_q  <= 1'b0;
            out_code_q   <= '0;
            ovf_q        <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                state_q[b]   <= state_d[b];
                cnt_q[b]     <= cnt_d[b];
                press_q[b]   <= ev_fire[b] && (ev_type[b] == EV_PRESS);
                release_q[b] <= ev_fire[b] && (ev_type[b] == EV_RELEASE);
                long_q[b]    <= ev_fire[b] && (ev_type[b] == EV_LONG);
                repeat_q[b]  <= ev_fire[b] && (ev_type[b] == EV_REPEAT);
            end
            pend_valid_q <= pend_valid_d;
            pend_type_q  <= pend_type_d;
            out_valid_q  <= out_valid_d;
            out_code_q   <= out_code_d;
            ovf_q        <= ovf_d;
        end
    end

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            held[b] = (state_q[b] != IDLE);
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;
    assign evt_valid     = out_valid_q;
    assign evt_code      = out_code_q;
    assign evt_overflow  = ovf_q;

endmodule

// File: tb/tb_button_event_gen.sv
// Scoreboard bench for button_event_gen with LONG_PRESS=8, REPEAT_PERIOD=4.
module tb_button_event_gen;
    localparam int LP = 8;
    localparam int RP = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] button_db = 2'b00;
    logic       evt_ready = 1'b1;
    logic [1:0] press_pulse, release_pulse, long_pulse, repeat_pulse, held;
    logic       evt_valid, evt_overflow;
    logic [2:0] evt_code;

    int n_checks = 0;
    int n_errors = 0;
    logic [2:0] exp_q[$];
    int pp_cnt[2], rl_cnt[2], lp_cnt[2], rp_cnt[2];

    button_event_gen #(.CNT_W(16), .LONG_PRESS(LP), .REPEAT_PERIOD(RP)) dut (
        .clk(clk), .reset(reset), .button_db(button_db),
        .press_pulse(press_pulse), .release_pulse(release_pulse),
        .long_pulse(long_pulse), .repeat_pulse(repeat_pulse), .held(held),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
        .evt_overflow(evt_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold button b for n sampled edges, then release for gap edges; expected events
    // follow from the hold length: long at 8 edges, repeats every 4 edges after.
    task automatic hold_btn(input int b, input int n, input int gap);
        logic id;
        id = (b == 1);
        exp_q.push_back({id, 2'b00});
        if (n - 1 >= LP) begin
            exp_q.push_back({id, 2'b10});
            for (int k = 1; LP + RP * k <= n - 1; k++) exp_q.push_back({id, 2'b11});
        end
        exp_q.push_back({id, 2'b01});
        button_db[b] = 1'b1;
        step(n);
        button_db[b] = 1'b0;
        step(gap);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++) begin
                if (press_pulse[b])   pp_cnt[b]++;
                if (release_pulse[b]) rl_cnt[b]++;
                if (long_pulse[b])    lp_cnt[b]++;
                if (repeat_pulse[b])  rp_cnt[b]++;
            end
            if (evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    check("evt_unexpected", 0, 1);
                end else begin
                    check("evt_code", {29'd0, evt_code}, {29'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        int pp0, rl0, lp0, rp0;
        logic [31:0] acc;

        // reset and idle
        step(3);
        check("rst_valid", evt_valid, 0);
        check("rst_pulses", {press_pulse, release_pulse, long_pulse, repeat_pulse}, 0);
        check("rst_held_ovf", {held, evt_overflow, evt_code}, 0);
        reset = 1'b0;
        acc = 0;
        repeat (20) begin
            @(negedge clk);
            acc = acc | {press_pulse, release_pulse, long_pulse, repeat_pulse, held,
                         evt_valid, evt_overflow, evt_code};
        end
        check("idle_quiet", acc, 0);
        step(1);

        // short press
        pp0 = pp_cnt[0]; rl0 = rl_cnt[0]; lp0 = lp_cnt[0];
        hold_btn(0, 3, 3);
        check("short_press_pulse", pp_cnt[0] - pp0, 1);
        check("short_release_pulse", rl_cnt[0] - rl0, 1);
        check("short_no_long", lp_cnt[0] - lp0, 0);

        // long press with repeats
        lp0 = lp_cnt[0]; rp0 = rp_cnt[0];
        hold_btn(0, 20, 4);
        check("long_pulse_cnt", lp_cnt[0] - lp0, 1);
        check("repeat_pulse_cnt", rp_cnt[0] - rp0, 2);
        check("held_after_release", held, 0);

        // boundary: exactly LP held edges gives no long, LP+1 gives long
        lp0 = lp_cnt[1];
        hold_btn(1, LP, 3);
        check("lp_boundary_none", lp_cnt[1] - lp0, 0);
        hold_btn(1, LP + 1, 3);
        check("lp_boundary_one", lp_cnt[1] - lp0, 1);

        for (int i = 0; i < 4; i++) begin
            hold_btn($urandom_range(0, 1), $urandom_range(1, 24), $urandom_range(2, 4));
        end

        // simultaneous press
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b100);
        button_db = 2'b11;
        step(3);
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b101);
        button_db = 2'b00;
        step(5);

        // overflow under backpressure
        check("ovf_before", evt_overflow, 0);
        evt_ready = 1'b0;
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b001);
        button_db = 2'b01; step(1);
        button_db = 2'b00; step(1);
        button_db = 2'b01; step(1);
        button_db = 2'b00; step(3);
        check("stall_valid", evt_valid, 1);
        check("ovf_set", evt_overflow, 1);
        repeat (3) begin
            @(negedge clk);
            check("stall_code", {29'd0, evt_code}, 0);
        end
        step(1);
        evt_ready = 1'b1;
        step(5);
        check("ovf_sticky", evt_overflow, 1);
        check("ovf_drained", evt_valid, 0);

        // reset while btn1 is in LONG with traffic stalled
        evt_ready = 1'b0;
        button_db = 2'b10;
        step(12);
        check("long_held", held, 2'b10);
        reset = 1'b1;
        exp_q.delete();
        step(2);
        check("rst2_valid_ovf", {evt_valid, evt_overflow}, 0);
        check("rst2_held", held, 0);
        evt_ready = 1'b1;
        reset = 1'b0;
        exp_q.push_back(3'b100);
        step(1);
        check("post_rst_edge1_valid", evt_valid, 0);
        check("post_rst_press_pulse", press_pulse, 2'b10);
        step(1);
        check("post_rst_edge2", {evt_valid, evt_code}, 4'b1100);
        exp_q.push_back(3'b101);
        button_db = 2'b00;
        step(4);

        for (int t = 0; t < 50 && exp_q.size() != 0; t++) step(1);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
